// File: rtl/muldiv_unit_pkg.sv
// Shared execute-stage types: decode ops, ALU functions, and the mul/div state encoding.
package muldiv_unit_pkg;

  localparam int XLEN  = 64;
  localparam int ITERS = XLEN;

  typedef enum logic [2:0] {
    OP_ALU, OP_ALUW, OP_LOAD, OP_STORE, OP_BRANCH, OP_JUMP, OP_SYSTEM
  } decode_op_t;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLL, ALU_SRL, ALU_SRA,
    ALU_SLT, ALU_SLTU, ALU_MULT, ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU
  } alufunc_t;

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} muldiv_state_t;

  function automatic logic [XLEN-1:0] word_sext(input logic [XLEN-1:0] v);
    return {{(XLEN-32){v[31]}}, v[31:0]};
  endfunction

endpackage

// File: rtl/muldiv_unit_div_core.sv
// Restoring divider, one quotient bit per step, with sign fixup on the outgoing values.
module muldiv_unit_div_core
  import muldiv_unit_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            step,
  input  logic            is_signed,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder
);

  logic [XLEN-1:0] dvd, dvs, rem;
  logic [XLEN-1:0] dvd_next, rem_next;
  logic [XLEN:0]   rem_sh, rem_diff;
  logic            qneg, rneg, qbit, sa, sb;

  assign sa = is_signed & dividend[XLEN-1];
  assign sb = is_signed & divisor[XLEN-1];

  // Partial remainder is kept one bit wider so divisors above 2^63 compare correctly.
  always_comb begin
    rem_sh    = {rem, dvd[XLEN-1]};
    rem_diff  = rem_sh - {1'b0, dvs};
    qbit      = (rem_sh >= {1'b0, dvs});
    rem_next  = qbit ? rem_diff[XLEN-1:0] : rem_sh[XLEN-1:0];
    dvd_next  = {dvd[XLEN-2:0], qbit};
    quotient  = qneg ? -dvd_next : dvd_next;
    remainder = rneg ? -rem_next : rem_next;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dvd  <= '0;
      dvs  <= '0;
      rem  <= '0;
      qneg <= 1'b0;
      rneg <= 1'b0;
    end else if (start) begin
      dvd  <= sa ? -dividend : dividend;
      dvs  <= sb ? -divisor : divisor;
      rem  <= '0;
      qneg <= sa ^ sb;
      rneg <= sa;
    end else if (step) begin
      dvd <= dvd_next;
      rem <= rem_next;
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with valid/ready handshake and flush.
// state | meaning
// IDLE  | ready for an operation
// MUL   | shift-add multiply, one bit per cycle
// DIV   | restoring divide, one quotient bit per cycle
// DONE  | result valid, held until taken
module muldiv_unit
  import muldiv_unit_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  alufunc_t        alufunc,
  input  logic            is_word,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(ITERS);

  muldiv_state_t   state, state_next;
  logic [CW-1:0]   counter;
  alufunc_t        op_func;
  logic            op_word;
  logic [XLEN-1:0] opa, opb, mul_a, mul_b, mul_acc, mul_acc_next;
  logic [XLEN-1:0] div_q, div_r, final_val, final_fixed;
  logic            accept, last, is_div_func, signed_func, div_zero;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign accept    = in_valid && in_ready && !flush;
  assign last      = (counter == CW'(ITERS-1));

  assign is_div_func = (alufunc == ALU_DIV) || (alufunc == ALU_DIVU) ||
                       (alufunc == ALU_REM) || (alufunc == ALU_REMU);
  assign signed_func = (alufunc == ALU_MULT) || (alufunc == ALU_DIV) ||
                       (alufunc == ALU_REM);
  assign div_zero    = is_div_func && (opb == '0);

  always_comb begin
    opa = src_a;
    opb = src_b;
    if (is_word) begin
      if (signed_func) begin
        opa = word_sext(src_a);
        opb = word_sext(src_b);
      end else begin
        opa = {{(XLEN-32){1'b0}}, src_a[31:0]};
        opb = {{(XLEN-32){1'b0}}, src_b[31:0]};
      end
    end
  end

  assign mul_acc_next = mul_acc + (mul_b[0] ? mul_a : '0);

  always_comb begin
    case (op_func)
      ALU_MULT:          final_val = mul_acc_next;
      ALU_DIV, ALU_DIVU: final_val = div_q;
      default:           final_val = div_r;
    endcase
    final_fixed = op_word ? word_sext(final_val) : final_val;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (accept) begin
        if (alufunc == ALU_MULT)          state_next = MUL;
        else if (is_div_func && !div_zero) state_next = DIV;
        else                               state_next = DONE;
      end
      MUL, DIV: if (last) state_next = DONE;
      DONE:     if (out_ready) state_next = IDLE;
      default:  state_next = IDLE;
    endcase
    if (flush) state_next = IDLE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      counter <= '0;
      op_func <= ALU_ADD;
      op_word <= 1'b0;
      mul_a   <= '0;
      mul_b   <= '0;
      mul_acc <= '0;
      result  <= '0;
    end else begin
      if (flush || !((state == MUL) || (state == DIV)) || last) counter <= '0;
      else                                                       counter <= counter + 1'b1;

      if (accept) begin
        op_func <= alufunc;
        op_word <= is_word;
        mul_a   <= opa;
        mul_b   <= opb;
        mul_acc <= '0;
        // Zero divisor and unsupported functions finish at accept time.
        if (div_zero) begin
          if ((alufunc == ALU_DIV) || (alufunc == ALU_DIVU)) result <= '1;
          else result <= is_word ? word_sext(opa) : opa;
        end else if (!is_div_func && (alufunc != ALU_MULT)) begin
          result <= '0;
        end
      end else if (state == MUL) begin
        mul_acc <= mul_acc_next;
        mul_a   <= mul_a << 1;
        mul_b   <= mul_b >> 1;
      end

      if (!flush && ((state == MUL) || (state == DIV)) && last) result <= final_fixed;
    end
  end

  muldiv_unit_div_core u_div_core (
    .clk       (clk),
    .reset     (reset),
    .start     (accept && is_div_func),
    .step      (state == DIV),
    .is_signed (signed_func),
    .dividend  (opa),
    .divisor   (opb),
    .quotient  (div_q),
    .remainder (div_r)
  );

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: directed ops, latency, backpressure, flush and reset.
module tb_muldiv_unit;
  import muldiv_unit_pkg::*;

  logic        clk = 1'b0;
  logic        reset, in_valid, in_ready, is_word, flush, out_valid, out_ready;
  alufunc_t    alufunc;
  logic [63:0] src_a, src_b, result;

  typedef struct {
    string       name;
    logic [63:0] val;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  muldiv_unit dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .alufunc   (alufunc),
    .is_word   (is_word),
    .src_a     (src_a),
    .src_b     (src_b),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out: got result %h with no pending op", result);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check(e.name, result, e.val);
      end
    end
  end

  task automatic send(input alufunc_t f, input logic w, input logic [63:0] a, input logic [63:0] b);
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout: in_ready still %b after %0d cycles", in_ready, n);
    end
    alufunc  = f;
    is_word  = w;
    src_a    = a;
    src_b    = b;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic run_op(input string name, input alufunc_t f, input logic w,
                        input logic [63:0] a, input logic [63:0] b,
                        input logic [63:0] exp, input int lat);
    int   n = 0;
    logic busy_ok = 1'b1;
    exp_q.push_back('{name, exp});
    send(f, w, a, b);
    do begin
      @(negedge clk);
      n++;
      if (in_ready) busy_ok = 1'b0;
    end while (!out_valid && n < 200);
    check({name, "_latency"}, 64'(n), 64'(lat));
    check({name, "_busy"}, 64'(busy_ok), 64'd1);
  endtask

  initial begin
    logic saw;
    reset = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    is_word = 1'b0; alufunc = ALU_ADD; src_a = '0; src_b = '0;
    repeat (3) @(negedge clk);
    check("reset_in_ready", 64'(in_ready), 64'd1);
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_result", result, 64'd0);
    reset = 1'b0;

    run_op("mult_7_m3", ALU_MULT, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 65);
    run_op("div_m7_2",  ALU_DIV,  1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 65);
    run_op("rem_m7_2",  ALU_REM,  1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 65);
    run_op("divu_100_7", ALU_DIVU, 1'b0, 64'd100, 64'd7, 64'd14, 65);
    run_op("remu_100_7", ALU_REMU, 1'b0, 64'd100, 64'd7, 64'd2, 65);
    run_op("divu_by0",  ALU_DIVU, 1'b0, 64'h1234, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1);
    run_op("remu_by0",  ALU_REMU, 1'b0, 64'h1234, 64'd0, 64'h1234, 1);
    run_op("div_ovf",   ALU_DIV,  1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
           64'h8000_0000_0000_0000, 65);
    run_op("rem_ovf",   ALU_REM,  1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 65);
    run_op("multw",     ALU_MULT, 1'b1, 64'h7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 65);
    run_op("divw",      ALU_DIV,  1'b1, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF,
           64'hFFFF_FFFF_8000_0000, 65);
    run_op("divuw",     ALU_DIVU, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'h0000_0000_7FFF_FFFF, 65);
    run_op("divu_bigdvs", ALU_DIVU, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0001, 64'd1, 65);
    run_op("unsupported", ALU_ADD, 1'b0, 64'd5, 64'd6, 64'd0, 1);

    // Backpressure: consumer stalls five cycles after the result appears.
    @(posedge clk);
    #1 out_ready = 1'b0;
    run_op("bp_divu", ALU_DIVU, 1'b0, 64'd100, 64'd7, 64'd14, 65);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_valid_held", 64'(out_valid), 64'd1);
      check("bp_result_held", result, 64'd14);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    @(negedge clk);
    check("bp_ready_same_cycle", 64'(in_ready), 64'd0);
    @(negedge clk);
    check("bp_ready_next_cycle", 64'(in_ready), 64'd1);

    // Asynchronous reset in the middle of a multiply.
    send(ALU_MULT, 1'b0, 64'd5, 64'd6);
    repeat (10) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("arst_in_ready", 64'(in_ready), 64'd1);
    check("arst_out_valid", 64'(out_valid), 64'd0);
    check("arst_result", result, 64'd0);
    @(negedge clk);
    reset = 1'b0;

    // Flush in cycle 30 of a divide.
    send(ALU_DIV, 1'b0, 64'd100, 64'd7);
    repeat (29) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    check("flush_div_ready", 64'(in_ready), 64'd1);
    saw = 1'b0;
    repeat (80) begin
      @(negedge clk);
      if (out_valid) saw = 1'b1;
    end
    check("flush_div_no_valid", 64'(saw), 64'd0);

    // Flush concurrent with an offered operation in IDLE.
    @(negedge clk);
    alufunc = ALU_DIVU; is_word = 1'b0; src_a = 64'd100; src_b = 64'd7;
    in_valid = 1'b1; flush = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0; flush = 1'b0;
    @(negedge clk);
    check("flush_idle_ready", 64'(in_ready), 64'd1);
    saw = 1'b0;
    repeat (70) begin
      @(negedge clk);
      if (out_valid) saw = 1'b1;
    end
    check("flush_idle_no_valid", 64'(saw), 64'd0);

    run_op("post_flush_mult", ALU_MULT, 1'b0, 64'd12345, 64'd1000, 64'd12345000, 65);

    @(negedge clk);
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

endmodule
